// File: rtl/rr_requester_2ch.sv
// Requester front end for a 2-request round-robin arbiter.
// Two FIFO channels, shared registered output, grant-protocol checker.
module rr_requester_2ch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic [1:0]       requests,
  input  logic [1:0]       grants,
  output logic             out_valid,
  output logic             out_id,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]       vld;
  logic [1:0]       rdy;
  logic [1:0]       push;
  logic [1:0]       req;
  logic [1:0]       pop;
  logic             both_g;
  logic [WIDTH-1:0] din  [2];
  logic [WIDTH-1:0] head [2];

  assign vld     = {in1_valid, in0_valid};
  assign din[0]  = in0_data;
  assign din[1]  = in1_data;
  assign both_g  = (grants == 2'b11);

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    assign rdy[c]  = !rst && (cnt_q != CW'(DEPTH));
    assign req[c]  = (cnt_q != '0);
    assign push[c] = vld[c] & rdy[c];
    assign pop[c]  = grants[c] & req[c] & !both_g;
    assign head[c] = mem_q[rptr_q];

    always_comb begin
      cnt_d = cnt_q;
      case ({push[c], pop[c]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[c]) wptr_q <= wptr_q + AW'(1);
        if (pop[c])  rptr_q <= rptr_q + AW'(1);
        cnt_q <= cnt_d;
      end
    end

    // storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
      if (push[c]) mem_q[wptr_q] <= din[c];
    end
  end

  assign in0_ready = rdy[0];
  assign in1_ready = rdy[1];
  assign requests  = req;

  logic             valid_q, valid_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  always_comb begin
    valid_d = |pop;
    id_d    = id_q;
    data_d  = data_q;
    unique case (1'b1)
      pop[0]: begin
        id_d   = 1'b0;
        data_d = head[0];
      end
      pop[1]: begin
        id_d   = 1'b1;
        data_d = head[1];
      end
      default: ;
    endcase
    err_d = err_q | both_g | (|(grants & ~req));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_id    = id_q;
  assign out_data  = data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rr_requester_2ch.sv
// Scoreboard bench for rr_requester_2ch with a behavioural
// round-robin arbiter that can be overridden by forced grants.
module tb_rr_requester_2ch;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic [1:0] requests;
  logic [1:0] grants;
  logic       out_valid;
  logic       out_id;
  logic [7:0] out_data;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  logic       force_en;
  logic [1:0] force_g;
  logic       rr_last;

  always #5 clk = ~clk;

  rr_requester_2ch #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .requests(requests), .grants(grants),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
    .err(err)
  );

  // round-robin arbiter; rr_last=1 means channel 0 has priority
  always_comb begin
    grants = 2'b00;
    if (force_en)                grants = force_g;
    else if (requests == 2'b11)  grants = rr_last ? 2'b01 : 2'b10;
    else                         grants = requests;
  end

  always @(posedge clk) begin
    if (rst) rr_last <= 1'b1;
    else if (!force_en && grants == 2'b01) rr_last <= 1'b0;
    else if (!force_en && grants == 2'b10) rr_last <= 1'b1;
  end

  task automatic chk(input string name, input logic [8:0] act,
                     input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor: every output word must match the head of the scoreboard
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: id %0d data %h", out_id, out_data);
      end else begin
        chk("out_word", {out_id, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("ready0_in_rst", {8'd0, in0_ready}, 9'd0);
    chk("ready1_in_rst", {8'd0, in1_ready}, 9'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; force_en = 1'b0; force_g = 2'b00;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00;
    step();
    do_reset();

    // idle after reset
    @(negedge clk);
    chk("idle_req",   {7'd0, requests}, 9'd0);
    chk("idle_rdy",   {7'd0, in1_ready, in0_ready}, 9'h003);
    chk("idle_valid", {8'd0, out_valid}, 9'd0);
    chk("idle_err",   {8'd0, err}, 9'd0);
    chk("idle_out",   {out_id, out_data}, 9'd0);

    // single word latency
    step();
    in0_valid = 1'b1; in0_data = 8'hA1;
    exp_q.push_back({1'b0, 8'hA1});
    step();
    in0_valid = 1'b0;
    @(negedge clk);
    chk("lat_req_t1", {7'd0, requests}, 9'h001);
    chk("lat_val_t1", {8'd0, out_valid}, 9'd0);
    step();
    @(negedge clk);
    chk("lat_val_t2", {8'd0, out_valid}, 9'h001);
    steps(3);

    // round-robin interleave
    do_reset();
    in0_valid = 1'b1; in0_data = 8'h10;
    in1_valid = 1'b1; in1_data = 8'h20;
    step();
    in0_data = 8'h11; in1_data = 8'h21;
    step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h21});
    steps(6);
    @(negedge clk);
    chk("rr_err", {8'd0, err}, 9'd0);
    chk("rr_drained", 9'(exp_q.size()), 9'd0);

    // fill ch1 under stalled grants
    force_en = 1'b1; force_g = 2'b00;
    in1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in1_data = 8'h30 + 8'(i);
      step();
    end
    in1_data = 8'h34;
    @(negedge clk);
    chk("full_rdy", {8'd0, in1_ready}, 9'd0);
    chk("full_req", {7'd0, requests}, 9'h002);
    step();
    in1_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h30 + 8'(i)});
    force_en = 1'b0;
    @(negedge clk);
    chk("full_rdy_pre", {8'd0, in1_ready}, 9'd0);
    step();
    @(negedge clk);
    chk("full_rdy_post", {8'd0, in1_ready}, 9'h001);
    steps(6);
    chk("full_drained", 9'(exp_q.size()), 9'd0);
    chk("full_err", {8'd0, err}, 9'd0);

    // double grant
    force_en = 1'b1; force_g = 2'b00;
    in0_valid = 1'b1; in0_data = 8'h40;
    in1_valid = 1'b1; in1_data = 8'h50;
    step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    force_g = 2'b11;
    steps(3);
    @(negedge clk);
    chk("dbl_err", {8'd0, err}, 9'h001);
    chk("dbl_req", {7'd0, requests}, 9'h003);
    force_g = 2'b00;
    step();
    exp_q.push_back({1'b0, 8'h40});
    exp_q.push_back({1'b1, 8'h50});
    force_en = 1'b0;
    steps(4);
    @(negedge clk);
    chk("dbl_err_sticky", {8'd0, err}, 9'h001);
    chk("dbl_drained", 9'(exp_q.size()), 9'd0);

    // grant to empty channel, then reset mid-stream
    do_reset();
    @(negedge clk);
    chk("rst_err_clr", {8'd0, err}, 9'd0);
    force_en = 1'b1; force_g = 2'b00;
    in0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0_data = 8'h61 + 8'(i);
      step();
    end
    in0_valid = 1'b0;
    force_g = 2'b10;
    step();
    @(negedge clk);
    chk("bad_g_err", {8'd0, err}, 9'h001);
    chk("bad_g_req", {7'd0, requests}, 9'h001);
    force_en = 1'b0;
    do_reset();
    @(negedge clk);
    chk("mid_rst_req", {7'd0, requests}, 9'd0);
    chk("mid_rst_err", {8'd0, err}, 9'd0);
    steps(5);
    chk("final_drained", 9'(exp_q.size()), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
